// File: rtl/step_pulse_counter.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_counter
// Brief    : Qualifies step pulses on a step/dir bus, accumulates them signed
//            by dir with saturation, and snapshots the count on an RD strobe.
// Revision : 1.0 - initial release
// ============================================================================
module step_pulse_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 100,
    parameter int CNT_MAX     = 127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       dir,
    input  logic       RD,
    output logic [7:0] N,
    output logic       ovf,
    output logic       busy
);

    localparam logic [1:0]        c_ST_IDLE     = 2'd0;
    localparam logic [1:0]        c_ST_COUNTING = 2'd1;
    localparam logic [1:0]        c_ST_HELD     = 2'd2;
    localparam logic [8:0]        c_QUAL_AT     = 9'(MIN_HIGH - 1);
    localparam logic signed [8:0] c_POS_MAX     = 9'(CNT_MAX);
    localparam logic signed [8:0] c_NEG_MAX     = -c_POS_MAX;
    localparam logic [1:0]        c_FILL        = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] r_step_sync;
    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic                   r_prev_rd;
    logic [1:0]             r_fill_cnt;
    logic                   r_hold_off;
    logic [1:0]             r_state;
    logic [8:0]             r_cnt;
    logic signed [8:0]      r_acc;
    logic                   r_sat;

    logic                   w_step_s;
    logic                   w_dir_s;
    logic                   w_rd_s;
    logic                   w_rd_evt;
    logic [1:0]             w_state_nxt;
    logic [8:0]             w_cnt_nxt;
    logic                   w_qual;
    logic signed [8:0]      w_acc_nxt;
    logic                   w_sat_hit;
    logic signed [8:0]      w_acc_unit;
    logic                   w_neg;
    logic [6:0]             w_mag;

    assign w_step_s = r_step_sync[SYNC_STAGES-1];
    assign w_dir_s  = r_dir_sync[SYNC_STAGES-1];
    assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
    assign w_rd_evt = r_prev_rd & ~w_rd_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_sync <= '0;
            r_dir_sync  <= '0;
            r_rd_sync   <= '1;
            r_prev_rd   <= 1'b1;
        end else begin
            r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step};
            r_dir_sync  <= {r_dir_sync[SYNC_STAGES-2:0], dir};
            r_rd_sync   <= {r_rd_sync[SYNC_STAGES-2:0], RD};
            r_prev_rd   <= w_rd_s;
        end
    end

    // The step chain holds reset zeros for SYNC_STAGES cycles after rst; a
    // genuine low must be seen after that before a rising step may qualify,
    // so a step already high across reset is never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt <= c_FILL;
            r_hold_off <= 1'b1;
        end else begin
            if (r_fill_cnt != 2'd0) begin
                r_fill_cnt <= r_fill_cnt - 2'd1;
            end else if (!w_step_s) begin
                r_hold_off <= 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_qual      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = 9'd0;
                if (w_step_s && !r_hold_off) begin
                    w_state_nxt = c_ST_COUNTING;
                    w_cnt_nxt   = 9'd1;
                end
            end
            c_ST_COUNTING: begin
                if (!w_step_s) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 9'd0;
                end else if (r_cnt == c_QUAL_AT) begin
                    w_qual      = 1'b1;
                    w_state_nxt = c_ST_HELD;
                    w_cnt_nxt   = 9'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 9'd1;
                end
            end
            c_ST_HELD: begin
                w_cnt_nxt = 9'd0;
                if (!w_step_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = 9'd0;
            end
        endcase
    end

    always_comb begin
        w_acc_unit = w_dir_s ? -9'sd1 : 9'sd1;
        w_acc_nxt  = r_acc;
        w_sat_hit  = 1'b0;
        if (w_qual) begin
            if (!w_dir_s) begin
                if (r_acc >= c_POS_MAX) begin
                    w_acc_nxt = c_POS_MAX;
                    w_sat_hit = 1'b1;
                end else begin
                    w_acc_nxt = r_acc + 9'sd1;
                end
            end else begin
                if (r_acc <= c_NEG_MAX) begin
                    w_acc_nxt = c_NEG_MAX;
                    w_sat_hit = 1'b1;
                end else begin
                    w_acc_nxt = r_acc - 9'sd1;
                end
            end
        end
    end

    assign w_neg = r_acc[8];
    assign w_mag = w_neg ? 7'(-r_acc) : r_acc[6:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 9'd0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            busy    <= (w_state_nxt == c_ST_COUNTING);
        end
    end

    // A read closes the window on the pre-qual value; a concurrent qual
    // opens the next window with its own +/-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 9'sd0;
            r_sat <= 1'b0;
            N     <= 8'h00;
            ovf   <= 1'b0;
        end else if (w_rd_evt) begin
            N     <= {w_neg, w_mag};
            ovf   <= r_sat;
            r_acc <= w_qual ? w_acc_unit : 9'sd0;
            r_sat <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            r_sat <= r_sat | w_sat_hit;
        end
    end

endmodule
`default_nettype wire
